// File: rtl/lmg_pkg.sv
// Shared constants, FSM state encoding and slot helpers for the LMG move-list sequencer.
package lmg_pkg;

  localparam int SLOTS      = 8;
  localparam int SLOT_WIDTH = 19;
  localparam int MOVE_WIDTH = 18;

  typedef enum logic [3:0] {
    IDLE,
    RST,
    WAIT,
    POP,
    LATCH,
    SCAN,
    HDR,
    TERM,
    FIN
  } state_t;

  // Each slot carries the move in its low bits and an invalid flag just above it.
  function automatic logic [MOVE_WIDTH-1:0] slot_move(input logic [SLOT_WIDTH-1:0] slot_bits);
    return slot_bits[MOVE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/lmg_slot_scan.sv
// Combinational slot selector: picks one slot of a latched LMG word and flags
// whether it is valid and whether the whole word carries no valid slot.
module lmg_slot_scan #(
  parameter int SLOTS      = lmg_pkg::SLOTS,
  parameter int SLOT_WIDTH = lmg_pkg::SLOT_WIDTH,
  parameter int IDX_WIDTH  = $clog2(SLOTS)
) (
  input  logic [SLOTS*SLOT_WIDTH-1:0]     word,
  input  logic [IDX_WIDTH-1:0]            idx,
  output logic [lmg_pkg::MOVE_WIDTH-1:0]  slot,
  output logic                            slot_valid,
  output logic                            all_invalid
);
  import lmg_pkg::*;

  logic [SLOT_WIDTH-1:0] sel;
  logic [SLOTS-1:0]      invalid_flags;

  always_comb begin
    sel = word[idx*SLOT_WIDTH +: SLOT_WIDTH];
    for (int i = 0; i < SLOTS; i++) begin
      invalid_flags[i] = word[i*SLOT_WIDTH + MOVE_WIDTH];
    end
    slot        = slot_move(sel);
    slot_valid  = ~sel[MOVE_WIDTH];
    all_invalid = &invalid_flags;
  end

endmodule

// File: rtl/lmg_sequencer.sv
// Drains the legal-move generator FIFO into a RAM move list:
// header word (move count) at base, moves at base+1.., zero terminator after the last move.
module lmg_sequencer #(
  parameter int ADDR_WIDTH = 15,
  parameter int SLOTS      = lmg_pkg::SLOTS,
  parameter int SLOT_WIDTH = lmg_pkg::SLOT_WIDTH,
  parameter int MAX_MOVES  = 200
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  output logic                        lmg_reset,
  input  logic                        lmg_done,
  input  logic                        lmg_fifo_empty,
  output logic                        lmg_rden,
  input  logic [SLOTS*SLOT_WIDTH-1:0] lmg_fifo_out,
  output logic                        ram_wren,
  output logic [ADDR_WIDTH-1:0]       ram_wraddr,
  output logic [31:0]                 ram_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [7:0]                  move_count
);
  import lmg_pkg::*;

  localparam int IDX_WIDTH = $clog2(SLOTS);

  state_t                      state, state_next;
  logic [ADDR_WIDTH-1:0]       base;
  logic [SLOTS*SLOT_WIDTH-1:0] word;
  logic [IDX_WIDTH-1:0]        slot_idx;
  logic                        rst_cnt;
  logic                        start_q;
  logic [MOVE_WIDTH-1:0]       slot;
  logic                        slot_valid;
  logic                        all_invalid;
  logic [ADDR_WIDTH-1:0]       tail_addr;
  logic                        start_rise;
  logic                        abort;
  logic                        last_slot;
  logic                        at_capacity;

  lmg_slot_scan #(
    .SLOTS      (SLOTS),
    .SLOT_WIDTH (SLOT_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_scan (
    .word        (word),
    .idx         (slot_idx),
    .slot        (slot),
    .slot_valid  (slot_valid),
    .all_invalid (all_invalid)
  );

  // Address one past the current list end; wraps modulo the RAM size.
  assign tail_addr   = base + ADDR_WIDTH'(move_count) + ADDR_WIDTH'(1);
  assign start_rise  = start & ~start_q;
  assign abort       = ~start & (state != IDLE) & (state != FIN);
  assign last_slot   = (slot_idx == IDX_WIDTH'(SLOTS - 1));
  assign at_capacity = (move_count == 8'(MAX_MOVES - 1));

  always_comb begin
    state_next = state;
    lmg_reset  = 1'b0;
    lmg_rden   = 1'b0;
    ram_wren   = 1'b0;
    ram_wraddr = '0;
    ram_wdata  = '0;
    busy       = (state != IDLE) && (state != FIN);
    done       = (state == FIN);
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_rise) state_next = RST;
        RST: begin
          lmg_reset = 1'b1;
          if (rst_cnt) state_next = WAIT;
        end
        WAIT:  if (lmg_done) state_next = lmg_fifo_empty ? HDR : POP;
        POP: begin
          lmg_rden   = 1'b1;
          state_next = LATCH;
        end
        LATCH: state_next = SCAN;
        SCAN: begin
          if (slot_valid) begin
            ram_wren   = 1'b1;
            ram_wraddr = tail_addr;
            ram_wdata  = {{(32-MOVE_WIDTH){1'b0}}, slot};
          end
          if (slot_valid && at_capacity) state_next = HDR;
          else if (last_slot)            state_next = all_invalid ? HDR : WAIT;
        end
        HDR: begin
          ram_wren   = 1'b1;
          ram_wraddr = base;
          ram_wdata  = {24'd0, move_count};
          state_next = TERM;
        end
        TERM: begin
          ram_wren   = 1'b1;
          ram_wraddr = tail_addr;
          state_next = FIN;
        end
        FIN:   if (!start) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath registers follow the state that is active this cycle; an abort skips the scan update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base       <= '0;
      word       <= '0;
      slot_idx   <= '0;
      rst_cnt    <= 1'b0;
      start_q    <= 1'b0;
      move_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_rise) begin
            base       <= base_addr;
            move_count <= '0;
            overflow   <= 1'b0;
            rst_cnt    <= 1'b0;
          end
        end
        RST:   rst_cnt <= 1'b1;
        LATCH: begin
          word     <= lmg_fifo_out;
          slot_idx <= '0;
        end
        SCAN: begin
          if (!abort) begin
            if (slot_valid) move_count <= move_count + 8'd1;
            if (slot_valid && at_capacity) overflow <= 1'b1;
            slot_idx <= slot_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lmg_sequencer.sv
// Directed bench for lmg_sequencer: behavioural LMG FIFO and RAM, with a scoreboard of expected RAM writes.
module tb_lmg_sequencer;

  localparam int AW = 15;
  localparam int SW = 19;
  localparam int WW = 8 * SW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          lmg_reset;
  logic          lmg_done;
  logic          lmg_fifo_empty;
  logic          lmg_rden;
  logic [WW-1:0] lmg_fifo_out;
  logic          ram_wren;
  logic [AW-1:0] ram_wraddr;
  logic [31:0]   ram_wdata;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [7:0]    move_count;

  wr_t           sb_q[$];
  logic [WW-1:0] fifo_q[$];
  logic [31:0]   ram [0:(1<<AW)-1];
  int            vectors;
  int            miscompares;
  int            rden_count;
  int            rden_before;
  logic [WW-1:0] w;

  lmg_sequencer #(
    .ADDR_WIDTH (AW),
    .SLOTS      (8),
    .SLOT_WIDTH (SW),
    .MAX_MOVES  (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .lmg_reset      (lmg_reset),
    .lmg_done       (lmg_done),
    .lmg_fifo_empty (lmg_fifo_empty),
    .lmg_rden       (lmg_rden),
    .lmg_fifo_out   (lmg_fifo_out),
    .ram_wren       (ram_wren),
    .ram_wraddr     (ram_wraddr),
    .ram_wdata      (ram_wdata),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .move_count     (move_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WW-1:0] invalid_word();
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*SW + 18] = 1'b1;
    return r;
  endfunction

  function automatic logic [WW-1:0] put_slot(input logic [WW-1:0] wd, input int i, input logic [17:0] v);
    logic [WW-1:0] r;
    r = wd;
    r[i*SW +: SW] = {1'b0, v};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [AW-1:0] b, input logic d);
    start     = s;
    base_addr = b;
    lmg_done  = d;
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic push_word(input logic [WW-1:0] wd);
    fifo_q.push_back(wd);
    lmg_fifo_empty = 1'b0;
  endtask

  // One clock: observe at the falling edge, then model the FIFO pop just after the rising edge.
  task automatic tick();
    logic pop;
    wr_t  e;
    @(negedge clk);
    checkOutput("rden_reset_exclusive", {31'd0, lmg_rden & lmg_reset}, 32'd0);
    if (ram_wren) begin
      checkOutput("unexpected_write", (sb_q.size() == 0) ? 32'd1 : 32'd0, 32'd0);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput("wr_addr", {17'd0, ram_wraddr}, {17'd0, e.addr});
        checkOutput("wr_data", ram_wdata, e.data);
      end
      ram[ram_wraddr] = ram_wdata;
    end
    if (lmg_rden) rden_count++;
    pop = lmg_rden;
    @(posedge clk);
    #1;
    if (pop) begin
      if (fifo_q.size() != 0) lmg_fifo_out = fifo_q.pop_front();
      lmg_fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 200 && !done; i++) tick();
    checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rden_count     = 0;
    reset          = 1'b1;
    lmg_fifo_empty = 1'b1;
    lmg_fifo_out   = '0;
    applyStimulus(1'b0, '0, 1'b0);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_lmg_reset", {31'd0, lmg_reset}, 32'd0);
    checkOutput("rst_rden", {31'd0, lmg_rden}, 32'd0);
    checkOutput("rst_wren", {31'd0, ram_wren}, 32'd0);
    checkOutput("rst_wraddr", {17'd0, ram_wraddr}, 32'd0);
    checkOutput("rst_wdata", ram_wdata, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_move_count", {24'd0, move_count}, 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] basic list: slots 0,3,7 then an all-invalid word");
    w = invalid_word();
    w = put_slot(w, 0, 18'h00011);
    w = put_slot(w, 3, 18'h00022);
    w = put_slot(w, 7, 18'h00033);
    push_word(w);
    push_word(invalid_word());
    expect_write(15'd17, 32'h11);
    expect_write(15'd18, 32'h22);
    expect_write(15'd19, 32'h33);
    expect_write(15'd16, 32'd3);
    expect_write(15'd20, 32'd0);
    applyStimulus(1'b1, 15'd16, 1'b0);
    tick();
    checkOutput("lmg_reset_cycle1", {31'd0, lmg_reset}, 32'd1);
    checkOutput("busy_run", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("lmg_reset_cycle2", {31'd0, lmg_reset}, 32'd1);
    tick();
    checkOutput("lmg_reset_cycle3", {31'd0, lmg_reset}, 32'd0);
    checkOutput("rden_in_wait", {31'd0, lmg_rden}, 32'd0);
    applyStimulus(1'b1, 15'd16, 1'b1);
    tick();
    checkOutput("rden_after_wait", {31'd0, lmg_rden}, 32'd1);
    run_to_done();
    checkOutput("basic_busy", {31'd0, busy}, 32'd0);
    checkOutput("basic_count", {24'd0, move_count}, 32'd3);
    checkOutput("basic_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("basic_ram16", ram[16], 32'd3);
    checkOutput("basic_ram17", ram[17], 32'h11);
    checkOutput("basic_ram18", ram[18], 32'h22);
    checkOutput("basic_ram19", ram[19], 32'h33);
    checkOutput("basic_ram20", ram[20], 32'd0);
    checkOutput("basic_sb_drained", sb_q.size(), 32'd0);
    applyStimulus(1'b0, 15'd16, 1'b0);
    tick();
    checkOutput("fin_release_done", {31'd0, done}, 32'd0);
    checkOutput("fin_release_busy", {31'd0, busy}, 32'd0);
    checkOutput("count_holds", {24'd0, move_count}, 32'd3);

    $display("[TB] empty list: generator done with nothing queued");
    rden_before = rden_count;
    expect_write(15'd16, 32'd0);
    expect_write(15'd17, 32'd0);
    applyStimulus(1'b1, 15'd16, 1'b1);
    run_to_done();
    checkOutput("empty_count", {24'd0, move_count}, 32'd0);
    checkOutput("empty_no_rden", rden_count - rden_before, 32'd0);
    checkOutput("empty_ram16", ram[16], 32'd0);
    checkOutput("empty_ram17", ram[17], 32'd0);
    checkOutput("empty_sb_drained", sb_q.size(), 32'd0);
    applyStimulus(1'b0, 15'd16, 1'b0);
    tick();

    $display("[TB] capacity: two full words against a 10-move limit");
    w = '0;
    for (int i = 0; i < 8; i++) w = put_slot(w, i, 18'h100 + 18'(i));
    push_word(w);
    for (int i = 0; i < 8; i++) expect_write(15'(17 + i), 32'h100 + 32'(i));
    w = '0;
    for (int i = 0; i < 8; i++) w = put_slot(w, i, 18'h200 + 18'(i));
    push_word(w);
    expect_write(15'd25, 32'h200);
    expect_write(15'd26, 32'h201);
    expect_write(15'd16, 32'd10);
    expect_write(15'd27, 32'd0);
    applyStimulus(1'b1, 15'd16, 1'b1);
    run_to_done();
    checkOutput("cap_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("cap_count", {24'd0, move_count}, 32'd10);
    checkOutput("cap_ram16", ram[16], 32'd10);
    checkOutput("cap_ram26", ram[26], 32'h201);
    checkOutput("cap_ram27", ram[27], 32'd0);
    checkOutput("cap_sb_drained", sb_q.size(), 32'd0);
    applyStimulus(1'b0, 15'd16, 1'b0);
    tick();
    checkOutput("overflow_holds", {31'd0, overflow}, 32'd1);

    $display("[TB] abort: start dropped while waiting on the generator");
    applyStimulus(1'b1, 15'd16, 1'b0);
    tick();
    checkOutput("abort_overflow_cleared", {31'd0, overflow}, 32'd0);
    checkOutput("abort_count_cleared", {24'd0, move_count}, 32'd0);
    tick();
    tick();
    checkOutput("abort_busy_wait", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 15'd16, 1'b0);
    tick();
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    repeat (4) tick();
    checkOutput("abort_done_later", {31'd0, done}, 32'd0);

    $display("[TB] wrap: list straddles the top of the address space");
    w = invalid_word();
    w = put_slot(w, 0, 18'h0000A);
    w = put_slot(w, 1, 18'h0000B);
    w = put_slot(w, 2, 18'h0000C);
    push_word(w);
    push_word(invalid_word());
    expect_write(15'h7FFF, 32'hA);
    expect_write(15'h0000, 32'hB);
    expect_write(15'h0001, 32'hC);
    expect_write(15'h7FFE, 32'd3);
    expect_write(15'h0002, 32'd0);
    applyStimulus(1'b1, 15'h7FFE, 1'b1);
    run_to_done();
    checkOutput("wrap_count", {24'd0, move_count}, 32'd3);
    checkOutput("wrap_ram0", ram[0], 32'hB);
    checkOutput("wrap_ram2", ram[2], 32'd0);
    checkOutput("wrap_sb_drained", sb_q.size(), 32'd0);
    applyStimulus(1'b0, 15'd16, 1'b0);
    tick();

    $display("[TB] reset asserted while scanning slot 4");
    w = '0;
    for (int i = 0; i < 8; i++) w = put_slot(w, i, 18'h300 + 18'(i));
    push_word(w);
    for (int i = 0; i < 4; i++) expect_write(15'(17 + i), 32'h300 + 32'(i));
    applyStimulus(1'b1, 15'd16, 1'b1);
    repeat (10) tick();
    checkOutput("slot4_wren", {31'd0, ram_wren}, 32'd1);
    checkOutput("slot4_wdata", ram_wdata, 32'h304);
    reset = 1'b0;
    #1;
    checkOutput("midrst_lmg_reset", {31'd0, lmg_reset}, 32'd0);
    checkOutput("midrst_rden", {31'd0, lmg_rden}, 32'd0);
    checkOutput("midrst_wren", {31'd0, ram_wren}, 32'd0);
    checkOutput("midrst_wraddr", {17'd0, ram_wraddr}, 32'd0);
    checkOutput("midrst_wdata", ram_wdata, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("midrst_count", {24'd0, move_count}, 32'd0);
    applyStimulus(1'b0, 15'd16, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("post_rst_sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lmg_sequencer.md
LMG_SEQUENCER -- requirements
Module: lmg_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_WIDTH, 15, RAM word address width; SLOTS, 8, move slots per LMG FIFO word; SLOT_WIDTH, 19, bits per slot (18 move bits + 1 invalid flag); MAX_MOVES, 200, move-list capacity.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; the block is held in reset while low.
REQ-004 start  in  1  level; rising edge starts a generation run; low aborts or acknowledges a run.
REQ-005 base_addr  in  ADDR_WIDTH  RAM address of the list header; sampled on the start edge.
REQ-006 lmg_reset  out  1  reset pulse to the LMG.
REQ-007 lmg_done  in  1  LMG has finished generating moves.
REQ-008 lmg_fifo_empty  in  1  LMG FIFO holds no words.
REQ-009 lmg_rden  out  1  one-cycle LMG FIFO pop.
REQ-010 lmg_fifo_out  in  SLOTS*SLOT_WIDTH  popped word, valid one cycle after lmg_rden.
REQ-011 ram_wren, ram_wraddr, ram_wdata  out  1, ADDR_WIDTH, 32  single-port RAM write.
REQ-012 busy, done, overflow  out  1 each  run in progress; list complete; capacity hit.
REQ-013 move_count  out  8  number of valid moves written.

Function
REQ-014 The FSM SHALL have the states IDLE, RST, WAIT, POP, LATCH, SCAN, HDR, TERM and FIN.
REQ-015 IDLE: on a start rising edge, capture base_addr, clear move_count and overflow, go to RST; busy=1 in every state except IDLE and FIN.
REQ-016 RST: lmg_reset=1 for exactly 2 cycles, then go to WAIT.
REQ-017 WAIT: if lmg_done=1 and lmg_fifo_empty=0, go to POP; if lmg_done=1 and lmg_fifo_empty=1, go to HDR.
REQ-018 POP: lmg_rden=1 for 1 cycle, then go to LATCH; LATCH captures lmg_fifo_out into a word register, resets the slot index to 0, and goes to SCAN.
REQ-019 Slot i SHALL be bits [SLOT_WIDTH*i+17 : SLOT_WIDTH*i]; its invalid flag SHALL be bit SLOT_WIDTH*i+18 (1 = invalid).
REQ-020 SCAN SHALL examine one slot per cycle, i = 0 to 7. For a valid slot: ram_wren=1, ram_wraddr = base+1+move_count, ram_wdata = {14'b0, slot}; move_count increments the next cycle.
REQ-021 When all 8 invalid flags of a latched word are 1, the run SHALL go to HDR after slot 7 and write no moves from that word.
REQ-022 Otherwise, after slot 7 the run SHALL return to WAIT.
REQ-023 A valid slot written when move_count = MAX_MOVES-1 SHALL set overflow=1 and go to HDR immediately; the remaining slots are dropped.
REQ-024 HDR: write {24'b0, move_count} to base; then go to TERM.
REQ-025 TERM: write 32'd0 to base+move_count+1; then go to FIN.
REQ-026 FIN: done=1 until start is low, then go to IDLE with done=0; move_count and overflow hold until the next start edge.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (wraps, no error).
REQ-028 start low in any state other than IDLE or FIN SHALL abort to IDLE the next cycle with no header or terminator write.
REQ-029 At most one RAM write SHALL occur per cycle; ram_wren=0 in all states other than SCAN (valid slot), HDR and TERM.
REQ-030 lmg_rden and lmg_reset SHALL never both be 1 in the same cycle.
REQ-031 A start edge while not in IDLE SHALL be ignored.

Reset
REQ-032 While reset=0, the FSM SHALL be in IDLE and every output SHALL be 0: lmg_reset, lmg_rden, ram_wren, ram_wraddr, ram_wdata, busy, done, overflow, move_count.
REQ-033 The internal base, word and slot registers SHALL be cleared to 0 by reset.
REQ-034 Reset asserted mid-run SHALL take effect immediately, with no partial-cycle RAM write.

Structure
REQ-035 A shared package lmg_pkg SHALL hold: SLOTS, SLOT_WIDTH, MOVE_WIDTH=18, the FSM state enum, and a slot-extract function.
REQ-036 One sub-module, lmg_slot_scan, SHALL be used: a combinational block giving the slot select/valid and the all-invalid flag for a word.
REQ-037 The existing Avalon controller SHALL drive start and base_addr=16 and arbitrate RAM write priority to this block while busy=1.

Verification
REQ-038 Stimulus: word with slots 0, 3, 7 valid (values 0x00011, 0x00022, 0x00033), then an all-invalid word. Response: RAM[17..19]=0x11, 0x22, 0x33; RAM[16]=3; RAM[20]=0; done=1.
REQ-039 Stimulus: lmg_done=1 with the FIFO empty on the first WAIT. Response: RAM[16]=0, RAM[17]=0, move_count=0, no lmg_rden.
REQ-040 Stimulus: MAX_MOVES=10, two fully valid words. Response: exactly 10 moves written, overflow=1, RAM[16]=10, RAM[27]=0.
REQ-041 Stimulus: reset low during SCAN of slot 4. Response: all outputs 0 that cycle, FSM in IDLE, no further writes.
REQ-042 Stimulus: start dropped in WAIT. Response: IDLE next cycle, no HDR/TERM writes, done stays 0.
REQ-043 Stimulus: start edge. Response: lmg_reset high for exactly cycles 1-2 after the edge; lmg_rden is asserted 1 cycle after WAIT sees lmg_done=1 with the FIFO non-empty.
